msg_buffer_scheduler: RTL and testbench

Controller for a pool of `N_BUFFERS` message_buffer instances on the NIC bus-to-network path. It steers incoming bus chunks into a free buffer and closes the buffer at burst end. It round-robin arbitrates completed buffers onto the single packet injection port, gated by per-vnet downstream space, and clears each buffer once its packet is accepted.

---
 rtl/msg_buffer_scheduler_pkg.sv | 20 ++
 rtl/msg_buffer_scheduler_rr_arbiter.sv | 35 +++
 rtl/msg_buffer_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_msg_buffer_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_buffer_scheduler_pkg.sv
// Shared definitions for the message-buffer scheduler.
//   buf_state_t     : lifecycle of one message buffer
//   ERR_* constants : bit positions of the sticky error-cause vector whose OR
//                     drives err_o
package msg_buffer_scheduler_pkg;

    typedef enum logic [2:0] {
        BUF_FREE     = 3'd0,
        BUF_FILLING  = 3'd1,
        BUF_CLOSED   = 3'd2,
        BUF_PENDING  = 3'd3,
        BUF_CLEARING = 3'd4
    } buf_state_t;

    localparam int ERR_STALL_DROP   = 0;  // chunk arrived while bus_stall_o high
    localparam int ERR_GRANT_NO_REQ = 1;  // inj_grant_i with no request standing
    localparam int ERR_TIMEOUT      = 2;  // filling buffer went idle too long
    localparam int N_ERR_CAUSES     = 3;

endpackage

// File: rtl/msg_buffer_scheduler_rr_arbiter.sv
// N-way round-robin arbiter.
//   req       : request vector
//   last_ptr  : index granted last; search starts at last_ptr+1 and wraps
//   gnt       : one-hot grant (all zero when no request)
//   gnt_idx   : index of the granted bit
//   gnt_valid : at least one request was granted
module msg_buffer_scheduler_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/msg_buffer_scheduler.sv
// Scheduler for a pool of message buffers on the bus-to-network path.
// Steers bus chunks into one FILLING buffer, closes it at burst end or when
// the buffer reports itself full, round-robins completed buffers onto the
// injection port (gated by downstream vnet space) and clears them on grant.
//
// Ports: clk/rst (sync, active-high); chunk_valid_i/burst_end_i bus side;
// bus_stall_o; buf_is_valid_o/buf_clear_o/buf_ready_i/buf_vnet_id_i to the
// buffers; vnet_free_i; inj_req_o/inj_sel_o/inj_vnet_id_o/inj_grant_i
// injection handshake; err_o sticky error flag.
//
// Optional feature macro MSG_SCHED_TIMEOUT_EN: a FILLING buffer that sees no
// chunk for TIMEOUT_CYCLES cycles is cleared and err_o is set.
//
// Per-buffer FSM state is held in state_q (one buf_state_t per buffer).
module msg_buffer_scheduler #(
    parameter int N_BUFFERS      = 4,
    parameter int N_BITS_BUF_ID  = 2,
    parameter int N_BITS_VNET_ID = 2,
    parameter int N_VNETS        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  chunk_valid_i,
    input  logic                                  burst_end_i,
    output logic                                  bus_stall_o,
    output logic [N_BUFFERS-1:0]                  buf_is_valid_o,
    output logic [N_BUFFERS-1:0]                  buf_clear_o,
    input  logic [N_BUFFERS-1:0]                  buf_ready_i,
    input  logic [N_BUFFERS*N_BITS_VNET_ID-1:0]   buf_vnet_id_i,
    input  logic [N_VNETS-1:0]                    vnet_free_i,
    output logic                                  inj_req_o,
    output logic [N_BITS_BUF_ID-1:0]              inj_sel_o,
    output logic [N_BITS_VNET_ID-1:0]             inj_vnet_id_o,
    input  logic                                  inj_grant_i,
    output logic                                  err_o
);
    import msg_buffer_scheduler_pkg::*;

    buf_state_t state_q [N_BUFFERS];
    buf_state_t state_d [N_BUFFERS];

    logic [N_BITS_BUF_ID-1:0]  rr_ptr_q;
    logic                      inj_req_q;
    logic [N_BITS_BUF_ID-1:0]  inj_sel_q;
    logic [N_BITS_VNET_ID-1:0] inj_vnet_q;
    logic [N_ERR_CAUSES-1:0]   err_cause_q;
    logic [N_ERR_CAUSES-1:0]   err_cause_d;

    logic                      filling_any, free_any, alloc, timeout;
    logic [N_BITS_BUF_ID-1:0]  fill_idx, free_idx, tgt_idx;
    logic [N_BUFFERS-1:0]      pend_req, arb_gnt;
    logic [N_BITS_BUF_ID-1:0]  arb_idx;
    logic                      arb_valid;
    logic [N_BITS_VNET_ID-1:0] vid, arb_vnet;

    // Occupancy decode; descending loop leaves the lowest FREE index.
    always_comb begin
        filling_any = 1'b0;
        fill_idx    = '0;
        free_any    = 1'b0;
        free_idx    = '0;
        pend_req    = '0;
        buf_clear_o = '0;
        vid         = '0;
        for (int k = N_BUFFERS - 1; k >= 0; k--) begin
            if (state_q[k] == BUF_FILLING) begin
                filling_any = 1'b1;
                fill_idx    = N_BITS_BUF_ID'(k);
            end
            if (state_q[k] == BUF_FREE) begin
                free_any = 1'b1;
                free_idx = N_BITS_BUF_ID'(k);
            end
            vid         = buf_vnet_id_i[k*N_BITS_VNET_ID +: N_BITS_VNET_ID];
            pend_req[k] = (state_q[k] == BUF_PENDING) && vnet_free_i[vid];
            buf_clear_o[k] = (state_q[k] == BUF_CLEARING);
        end
    end

    assign bus_stall_o    = !filling_any && !free_any;
    assign alloc          = chunk_valid_i && !filling_any && free_any;
    assign tgt_idx        = filling_any ? fill_idx : free_idx;
    assign buf_is_valid_o = (chunk_valid_i && !bus_stall_o)
                          ? ({{(N_BUFFERS-1){1'b0}}, 1'b1} << tgt_idx) : '0;

`ifdef MSG_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt_q;

    // Ready from the buffer wins over timeout: a full message is kept.
    assign timeout = filling_any && !chunk_valid_i && !buf_ready_i[fill_idx]
                   && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !filling_any || chunk_valid_i || timeout) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    msg_buffer_scheduler_rr_arbiter #(
        .N     (N_BUFFERS),
        .IDX_W (N_BITS_BUF_ID)
    ) u_arb (
        .req       (pend_req),
        .last_ptr  (rr_ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        arb_vnet = '0;
        for (int k = 0; k < N_BUFFERS; k++) begin
            if (arb_gnt[k]) arb_vnet = buf_vnet_id_i[k*N_BITS_VNET_ID +: N_BITS_VNET_ID];
        end
    end

    // Next-state logic. Buffer ready has priority over burst end, so a
    // simultaneous burst_end_i/buf_ready_i goes straight to PENDING.
    always_comb begin
        for (int k = 0; k < N_BUFFERS; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                BUF_FREE:
                    if (alloc && free_idx == N_BITS_BUF_ID'(k))
                        state_d[k] = burst_end_i ? BUF_CLOSED : BUF_FILLING;
                BUF_FILLING:
                    if (buf_ready_i[k])                    state_d[k] = BUF_PENDING;
                    else if (chunk_valid_i && burst_end_i) state_d[k] = BUF_CLOSED;
                    else if (timeout)                      state_d[k] = BUF_CLEARING;
                BUF_CLOSED:
                    if (buf_ready_i[k]) state_d[k] = BUF_PENDING;
                BUF_PENDING:
                    if (inj_req_q && inj_grant_i && inj_sel_q == N_BITS_BUF_ID'(k))
                        state_d[k] = BUF_CLEARING;
                BUF_CLEARING:
                    state_d[k] = BUF_FREE;
                default:
                    state_d[k] = BUF_FREE;
            endcase
        end
        err_cause_d = '0;
        err_cause_d[ERR_STALL_DROP]   = chunk_valid_i && bus_stall_o;
        err_cause_d[ERR_GRANT_NO_REQ] = inj_grant_i && !inj_req_q;
        err_cause_d[ERR_TIMEOUT]      = timeout;
    end

    // Injection handshake: inj_req_o/inj_sel_o/inj_vnet_id_o are registered
    // and held unchanged while inj_req_o is high; a transfer happens in the
    // cycle where inj_req_o and inj_grant_i are both high. Arbitration runs
    // only while no request stands, so the next offer follows a grant by at
    // least two cycles and a vnet going busy never withdraws an offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_BUFFERS; k++) state_q[k] <= BUF_FREE;
            rr_ptr_q    <= N_BITS_BUF_ID'(N_BUFFERS - 1);
            inj_req_q   <= 1'b0;
            inj_sel_q   <= '0;
            inj_vnet_q  <= '0;
            err_cause_q <= '0;
        end else begin
            for (int k = 0; k < N_BUFFERS; k++) state_q[k] <= state_d[k];
            err_cause_q <= err_cause_q | err_cause_d;
            if (inj_req_q) begin
                if (inj_grant_i) begin
                    inj_req_q <= 1'b0;
                    rr_ptr_q  <= inj_sel_q;
                end
            end else if (arb_valid) begin
                inj_req_q  <= 1'b1;
                inj_sel_q  <= arb_idx;
                inj_vnet_q <= arb_vnet;
            end
        end
    end

    assign inj_req_o     = inj_req_q;
    assign inj_sel_o     = inj_sel_q;
    assign inj_vnet_id_o = inj_vnet_q;
    assign err_o         = |err_cause_q;

endmodule

// File: tb/tb_msg_buffer_scheduler.sv
// Self-checking bench for msg_buffer_scheduler. Expected injection order is
// kept in a scoreboard queue filled when buffers are made ready and drained
// as the DUT offers packets.
module tb_msg_buffer_scheduler;

    localparam int N  = 4;
    localparam int BW = 2;
    localparam int VW = 2;
    localparam int NV = 4;
`ifdef MSG_SCHED_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          chunk_valid, burst_end, bus_stall;
    logic [N-1:0]  buf_is_valid, buf_clear, buf_ready;
    logic [N*VW-1:0] buf_vnet_id;
    logic [NV-1:0] vnet_free;
    logic          inj_req, inj_grant, err;
    logic [BW-1:0] inj_sel;
    logic [VW-1:0] inj_vnet;

    logic [VW-1:0] tb_vnet [N];
    logic [N-1:0]  tb_busy;
    logic [BW-1:0] exp_q[$];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        buf_vnet_id = '0;
        for (int k = 0; k < N; k++) buf_vnet_id[k*VW +: VW] = tb_vnet[k];
    end

    msg_buffer_scheduler #(
        .N_BUFFERS(N), .N_BITS_BUF_ID(BW), .N_BITS_VNET_ID(VW),
        .N_VNETS(NV), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .chunk_valid_i(chunk_valid), .burst_end_i(burst_end),
        .bus_stall_o(bus_stall), .buf_is_valid_o(buf_is_valid),
        .buf_clear_o(buf_clear), .buf_ready_i(buf_ready),
        .buf_vnet_id_i(buf_vnet_id), .vnet_free_i(vnet_free),
        .inj_req_o(inj_req), .inj_sel_o(inj_sel), .inj_vnet_id_o(inj_vnet),
        .inj_grant_i(inj_grant), .err_o(err)
    );

    function automatic logic [N-1:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one burst; the target is the model's lowest non-busy buffer.
    task automatic send_burst(input int len, input logic [VW-1:0] vnet,
                              output int idx, output logic [N-1:0] first,
                              output bit steady);
        idx = 0;
        while (idx < N - 1 && tb_busy[idx]) idx++;
        tb_busy[idx] = 1'b1;
        tb_vnet[idx] = vnet;
        steady = 1'b1;
        first = '0;
        for (int i = 0; i < len; i++) begin
            chunk_valid = 1'b1;
            burst_end = (i == len - 1);
            #1;
            if (i == 0) first = buf_is_valid;
            else if (buf_is_valid !== first) steady = 1'b0;
            tick();
        end
        chunk_valid = 1'b0;
        burst_end = 1'b0;
    endtask

    // Scoreboard consumer: waits for an offer, compares it with the queue
    // head, holds it for 'hold' cycles, grants, then checks the clear pulse.
    task automatic serve_one(input int hold);
        int waited = 0;
        logic [BW-1:0] e;
        while (inj_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (inj_req !== 1'b1) begin
            failures++;
            $display("FAIL serve_wait_req inj_req=%0b exp=1 after %0d cycles", inj_req, waited);
            return;
        end
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL serve_unexpected_offer inj_sel=%0d exp=none", inj_sel);
            return;
        end
        e = exp_q.pop_front();
        if (inj_sel !== e) begin
            failures++;
            $display("FAIL serve_sel got=%0d exp=%0d", inj_sel, e);
        end
        checks++;
        if (inj_vnet !== tb_vnet[e]) begin
            failures++;
            $display("FAIL serve_vnet got=%0d exp=%0d", inj_vnet, tb_vnet[e]);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (inj_req !== 1'b1 || inj_sel !== e) begin
                failures++;
                $display("FAIL serve_hold req=%0b sel=%0d exp req=1 sel=%0d", inj_req, inj_sel, e);
            end
        end
        inj_grant = 1'b1;
        tick();
        inj_grant = 1'b0;
        checks++;
        if (buf_clear !== oh(e) || inj_req !== 1'b0) begin
            failures++;
            $display("FAIL serve_clear clear=%b req=%0b exp clear=%b req=0", buf_clear, inj_req, oh(e));
        end
        buf_ready[e] = 1'b0;
        tb_busy[e] = 1'b0;
        tick();
        checks++;
        if (buf_clear !== 4'b0000) begin
            failures++;
            $display("FAIL serve_clear_end clear=%b exp=0000", buf_clear);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; chunk_valid = 1'b0; burst_end = 1'b0; buf_ready = '0;
        vnet_free = '0; inj_grant = 1'b0; tb_busy = '0; exp_q.delete();
        for (int k = 0; k < N; k++) tb_vnet[k] = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (inj_req !== 1'b0)      begin failures++; $display("FAIL rst_inj_req got=%0b exp=0", inj_req); end
        checks++; if (inj_sel !== 2'd0)      begin failures++; $display("FAIL rst_inj_sel got=%0d exp=0", inj_sel); end
        checks++; if (inj_vnet !== 2'd0)     begin failures++; $display("FAIL rst_inj_vnet got=%0d exp=0", inj_vnet); end
        checks++; if (buf_clear !== 4'b0)    begin failures++; $display("FAIL rst_buf_clear got=%b exp=0000", buf_clear); end
        checks++; if (err !== 1'b0)          begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
        checks++; if (bus_stall !== 1'b0)    begin failures++; $display("FAIL rst_bus_stall got=%0b exp=0", bus_stall); end
        checks++; if (buf_is_valid !== 4'b0) begin failures++; $display("FAIL rst_is_valid got=%b exp=0000", buf_is_valid); end
    endtask

`ifdef MSG_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        chunk_valid = 1'b1; burst_end = 1'b0;
        tick();
        chunk_valid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            checks++;
            if (buf_clear !== ((j == 8) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL timeout_clear idle=%0d got=%b", j, buf_clear);
            end
        end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0b exp=1", err); end
        tick();
    endtask
`endif

    task automatic test_single_burst;
        int idx; logic [N-1:0] first; bit steady;
        vnet_free = 4'b1111;
        send_burst(3, 2'd1, idx, first, steady);
        checks++; if (first !== oh(idx) || !steady) begin failures++; $display("FAIL single_is_valid got=%b steady=%0b exp=%b", first, steady, oh(idx)); end
        buf_ready[idx] = 1'b1;
        exp_q.push_back(BW'(idx));
        tick();
        checks++; if (inj_req !== 1'b0) begin failures++; $display("FAIL single_latency1 inj_req=%0b exp=0", inj_req); end
        tick();
        checks++; if (inj_req !== 1'b1) begin failures++; $display("FAIL single_latency2 inj_req=%0b exp=1", inj_req); end
        vnet_free = 4'b0000;  // must not withdraw the standing offer
        serve_one(2);
        vnet_free = 4'b1111;
    endtask

    task automatic test_back_to_back;
        int idx; logic [N-1:0] first; bit steady;
        logic [VW-1:0] vn [N];
        vn[0] = 2'd2; vn[1] = 2'd0; vn[2] = 2'd1; vn[3] = 2'd0;
        vnet_free = 4'b0000;
        for (int b = 0; b < N; b++) begin
            send_burst($urandom_range(1, 3), vn[b], idx, first, steady);
            checks++;
            if (first !== oh(b) || !steady) begin
                failures++;
                $display("FAIL b2b_alloc burst=%0d got=%b steady=%0b exp=%b", b, first, steady, oh(b));
            end
        end
        chunk_valid = 1'b1; burst_end = 1'b1;
        #1;
        checks++; if (bus_stall !== 1'b1)    begin failures++; $display("FAIL b2b_stall got=%0b exp=1", bus_stall); end
        checks++; if (buf_is_valid !== 4'b0) begin failures++; $display("FAIL b2b_drop_valid got=%b exp=0000", buf_is_valid); end
        tick();
        chunk_valid = 1'b0; burst_end = 1'b0;
        checks++; if (err !== 1'b1)          begin failures++; $display("FAIL b2b_err got=%0b exp=1", err); end
    endtask

    task automatic test_vnet_arbitration;
        buf_ready = 4'b1110;
        tick(); tick(); tick();
        checks++; if (inj_req !== 1'b0) begin failures++; $display("FAIL arb_no_vnet inj_req=%0b exp=0", inj_req); end
        vnet_free = 4'b0010;
        exp_q.push_back(2'd2);
        serve_one(0);
        vnet_free = 4'b0011;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        serve_one(1);
        serve_one(0);
        buf_ready[0] = 1'b1;
        vnet_free = 4'b0111;
        exp_q.push_back(2'd0);
        serve_one(0);
    endtask

    task automatic test_ready_close;
        vnet_free = 4'b1111;
        // burst_end and buf_ready together
        tb_busy[0] = 1'b1; tb_vnet[0] = 2'd3;
        chunk_valid = 1'b1; burst_end = 1'b0;
        #1;
        checks++; if (buf_is_valid !== 4'b0001) begin failures++; $display("FAIL same_alloc got=%b exp=0001", buf_is_valid); end
        tick();
        burst_end = 1'b1; buf_ready[0] = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        chunk_valid = 1'b0; burst_end = 1'b0;
        checks++; if (inj_req !== 1'b0) begin failures++; $display("FAIL same_latency1 inj_req=%0b exp=0", inj_req); end
        tick();
        checks++; if (inj_req !== 1'b1) begin failures++; $display("FAIL same_latency2 inj_req=%0b exp=1", inj_req); end
        serve_one(0);
        // buffer full mid-burst: next chunk opens a new buffer
        tb_busy[0] = 1'b1; tb_vnet[0] = 2'd1;
        chunk_valid = 1'b1;
        tick();
        chunk_valid = 1'b0; buf_ready[0] = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        tb_busy[1] = 1'b1; tb_vnet[1] = 2'd2;
        chunk_valid = 1'b1;
        #1;
        checks++; if (buf_is_valid !== 4'b0010) begin failures++; $display("FAIL midburst_realloc got=%b exp=0010", buf_is_valid); end
        tick();
        burst_end = 1'b1;
        tick();
        chunk_valid = 1'b0; burst_end = 1'b0;
        serve_one(0);
        buf_ready[1] = 1'b1;
        exp_q.push_back(2'd1);
        serve_one(0);
    endtask

    task automatic test_reset_mid;
        int idx; logic [N-1:0] first; bit steady; int waited = 0;
        send_burst(1, 2'd0, idx, first, steady);
        send_burst(1, 2'd1, idx, first, steady);
        buf_ready[idx] = 1'b1;
        while (inj_req !== 1'b1 && waited < 10) begin tick(); waited++; end
        checks++; if (inj_req !== 1'b1 || inj_sel !== 2'd1) begin failures++; $display("FAIL mid_setup req=%0b sel=%0d exp req=1 sel=1", inj_req, inj_sel); end
        rst = 1'b1;
        tick();
        checks++;
        if (inj_req !== 1'b0 || inj_sel !== 2'd0 || inj_vnet !== 2'd0 || buf_clear !== 4'b0
            || err !== 1'b0 || bus_stall !== 1'b0 || buf_is_valid !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset req=%0b sel=%0d vnet=%0d clr=%b err=%0b stall=%0b val=%b exp all 0",
                     inj_req, inj_sel, inj_vnet, buf_clear, err, bus_stall, buf_is_valid);
        end
        rst = 1'b0; buf_ready = '0; tb_busy = '0; exp_q.delete();
        chunk_valid = 1'b1; burst_end = 1'b1;
        #1;
        checks++; if (buf_is_valid !== 4'b0001) begin failures++; $display("FAIL mid_realloc got=%b exp=0001", buf_is_valid); end
        tick();
        chunk_valid = 1'b0; burst_end = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
`ifdef MSG_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_single_burst();
        test_back_to_back();
        test_vnet_arbitration();
        test_ready_close();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
